// File: rtl/serial_tx_arb_pkg.sv
// Shared types and constants for the 4-requester serial transmitter:
// FSM encoding, requester count, frame geometry and a one-hot decode helper.
package serial_tx_arb_pkg;

   localparam int NREQ       = 4;
   localparam int PTR_W      = $clog2(NREQ);
   localparam int FRAME_BITS = 10;              // start + 8 data + parity
   localparam int DATA_BITS  = FRAME_BITS - 2;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_GAP    = 3'd4
   } state_e;

   function automatic logic [PTR_W-1:0] onehot_to_idx(input logic [NREQ-1:0] oh);
      logic [PTR_W-1:0] idx;
      idx = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (oh[i]) idx = PTR_W'(i);
      end
      return idx;
   endfunction

endpackage

// File: rtl/serial_tx_arb_rr_arb4.sv
// Combinational round-robin arbiter: the search starts one past the last
// granted requester and wraps, so the nearest active requester wins.
module rr_arb4
   import serial_tx_arb_pkg::*;
(
   input  logic [NREQ-1:0]  req_i,
   input  logic [PTR_W-1:0] last_i,
   output logic [NREQ-1:0]  gnt_o
);

   logic [PTR_W-1:0] idx;

   // Walk from the farthest candidate to the nearest so the nearest overwrites.
   always_comb begin
      gnt_o = '0;
      idx   = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = last_i + PTR_W'(k);
         if (req_i[idx]) gnt_o = NREQ'(1) << idx;
      end
   end

endmodule

// File: rtl/serial_tx_arb.sv
// Arbitrates four byte requesters and serializes the winner's byte as
// start(1), D7..D0, even parity, followed by a low inter-frame gap.
module serial_tx_arb
   import serial_tx_arb_pkg::*;
#(
   parameter int IDLE_GAP = 2
)(
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic [NREQ-1:0]      req_i,
   input  logic [8*NREQ-1:0]    pdin_i,
   output logic [NREQ-1:0]      gnt_o,
   output logic [NREQ-1:0]      done_o,
   output logic                 sdout_o,
   output logic                 busy_o
);

   state_e           state_q, state_d;
   logic [7:0]       shift_q, shift_d;
   logic [2:0]       bit_cnt_q, bit_cnt_d;
   logic [3:0]       gap_cnt_q, gap_cnt_d;
   logic             parity_q, parity_d;
   logic [PTR_W-1:0] ptr_q, ptr_d;
   logic             sdout_q, sdout_d;
   logic [NREQ-1:0]  gnt_q, gnt_d;
   logic [NREQ-1:0]  done_q, done_d;

   logic [NREQ-1:0]  win_oh;
   logic [PTR_W-1:0] win_idx;
   logic [7:0]       win_byte;

   rr_arb4 u_arb (
      .req_i  (req_i),
      .last_i (ptr_q),
      .gnt_o  (win_oh)
   );

   assign win_idx  = onehot_to_idx(win_oh);
   assign win_byte = pdin_i[{win_idx, 3'b000} +: 8];

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q   <= ST_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         gap_cnt_q <= '0;
         parity_q  <= 1'b0;
         ptr_q     <= PTR_W'(NREQ - 1);
         sdout_q   <= 1'b0;
         gnt_q     <= '0;
         done_q    <= '0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         gap_cnt_q <= gap_cnt_d;
         parity_q  <= parity_d;
         ptr_q     <= ptr_d;
         sdout_q   <= sdout_d;
         gnt_q     <= gnt_d;
         done_q    <= done_d;
      end
   end

   // The shift register advances as each data bit is loaded into the line flop.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      gap_cnt_d = gap_cnt_q;
      parity_d  = parity_q;
      ptr_d     = ptr_q;
      case (state_q)
         ST_IDLE: begin
            if (|req_i) begin
               state_d  = ST_START;
               shift_d  = win_byte;
               parity_d = ^win_byte;
               ptr_d    = win_idx;
            end
         end
         ST_START: begin
            state_d   = ST_DATA;
            bit_cnt_d = '0;
            shift_d   = {shift_q[6:0], 1'b0};
         end
         ST_DATA: begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
               state_d = ST_PARITY;
            end else begin
               shift_d = {shift_q[6:0], 1'b0};
            end
         end
         ST_PARITY: begin
            state_d   = ST_GAP;
            gap_cnt_d = '0;
         end
         ST_GAP: begin
            if (gap_cnt_q == 4'(IDLE_GAP - 1)) begin
               state_d   = ST_IDLE;
               gap_cnt_d = '0;
            end else begin
               gap_cnt_d = gap_cnt_q + 4'd1;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Outputs are computed for the coming state so they leave straight from flops.
   always_comb begin
      sdout_d = 1'b0;
      gnt_d   = '0;
      done_d  = '0;
      case (state_q)
         ST_IDLE: begin
            if (|req_i) begin
               sdout_d = 1'b1;
               gnt_d   = win_oh;
            end
         end
         ST_START:  sdout_d = shift_q[7];
         ST_DATA:   sdout_d = (bit_cnt_q == 3'(DATA_BITS - 1)) ? parity_q : shift_q[7];
         ST_PARITY: done_d  = NREQ'(1) << ptr_q;
         default:   sdout_d = 1'b0;
      endcase
   end

   assign sdout_o = sdout_q;
   assign gnt_o   = gnt_q;
   assign done_o  = done_q;
   assign busy_o  = (state_q != ST_IDLE);

endmodule
